// File: rtl/fasm_dpsram_arb.sv
// ---------------------------------------------------------------------------
// fasm_dpsram_arb
//
// Round-robin arbiter that shares one port of a synchronous dual-port SRAM
// (registered address, 1-cycle read latency, write-through) between two
// wishbone-style masters A and B. Each access runs GRANT -> ACCESS -> RESP:
// the SRAM strobe is driven for exactly one cycle (ACCESS), and the owner's
// ack is pulsed in the following cycle (RESP) while the SRAM output is valid.
//
// Optional feature macro: FASM_ARB_LOCK_EN
//   Defined   : an owner holding its lck input high in RESP keeps the grant and
//               goes straight back to ACCESS, bypassing round-robin.
//   Undefined : alck_i/blck_i are ignored; pure round-robin.
//
// Parameters
//   AW  address width (SRAM depth 2^AW)
//   DW  data width
//
// Ports
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   adat_i/aadr_i/awre_i/astb_i      master A write data, address, we, strobe
//   alck_i                           master A lock request
//   adat_o/aack_o                    master A read data, 1-cycle ack
//   bdat_i..blck_i, bdat_o, back_o   same for master B
//   mdat_o/madr_o/mwre_o/mstb_o      to SRAM dat_i/adr_i/wre_i/stb_i
//   mdat_i                           from SRAM dat_o
//   gnt_o                            current owner one-hot {B,A}, 00 when idle
// ---------------------------------------------------------------------------
module fasm_dpsram_arb #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] adat_i,
  input  logic [AW-1:0] aadr_i,
  input  logic          awre_i,
  input  logic          astb_i,
  input  logic          alck_i,
  output logic [DW-1:0] adat_o,
  output logic          aack_o,
  input  logic [DW-1:0] bdat_i,
  input  logic [AW-1:0] badr_i,
  input  logic          bwre_i,
  input  logic          bstb_i,
  input  logic          blck_i,
  output logic [DW-1:0] bdat_o,
  output logic          back_o,
  output logic [DW-1:0] mdat_o,
  output logic [AW-1:0] madr_o,
  output logic          mwre_o,
  output logic          mstb_o,
  input  logic [DW-1:0] mdat_i,
  output logic [1:0]    gnt_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_sel;    // owner: 0 = A, 1 = B
  logic       r_last;   // last master served: 0 = A, 1 = B
  logic       r_aack;
  logic       r_back;
  logic [1:0] r_gnt;

  logic w_own_stb;
  logic w_oth_stb;
  logic w_pick;
  logic w_keep;

  assign w_own_stb = r_sel ? bstb_i : astb_i;
  assign w_oth_stb = r_sel ? astb_i : bstb_i;

  // From IDLE: with both requesting, serve the one that was not served last;
  // otherwise serve whichever is requesting (B only if B alone requests).
  assign w_pick = (astb_i & bstb_i) ? ~r_last : bstb_i;

`ifdef FASM_ARB_LOCK_EN
  assign w_keep = r_sel ? blck_i : alck_i;
`else
  logic w_unused_lck;
  assign w_unused_lck = alck_i ^ blck_i;
  assign w_keep       = 1'b0;
`endif

  // SRAM port follows the owner; only the strobe is qualified by ACCESS.
  // An owner dropping stb during ACCESS aborts without touching the SRAM.
  assign madr_o = r_sel ? badr_i : aadr_i;
  assign mdat_o = r_sel ? bdat_i : adat_i;
  assign mwre_o = r_sel ? bwre_i : awre_i;
  assign mstb_o = (r_state == S_ACCESS) & w_own_stb;

  // Read data is the raw SRAM output; it is meaningful only with ack.
  assign adat_o = mdat_i;
  assign bdat_o = mdat_i;

  assign aack_o = r_aack;
  assign back_o = r_back;
  assign gnt_o  = r_gnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_aack  <= 1'b0;
      r_back  <= 1'b0;
      r_gnt   <= 2'b00;
    end else begin
      r_aack <= 1'b0;
      r_back <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (astb_i | bstb_i) begin
            r_sel   <= w_pick;
            r_gnt   <= w_pick ? 2'b10 : 2'b01;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (w_own_stb) begin
            r_aack  <= ~r_sel;
            r_back  <= r_sel;
            r_state <= S_RESP;
          end else begin
            // Abort: no ack and the last-served pointer is left alone.
            r_gnt   <= 2'b00;
            r_state <= S_IDLE;
          end
        end
        S_RESP: begin
          r_last <= r_sel;
          if (w_keep) begin
            // Locked owner re-enters ACCESS; a dropped stb there aborts to IDLE.
            r_state <= S_ACCESS;
          end else if (w_oth_stb) begin
            // Owner is excluded here, so a same-owner re-request waits for IDLE.
            r_sel   <= ~r_sel;
            r_gnt   <= r_sel ? 2'b01 : 2'b10;
            r_state <= S_ACCESS;
          end else begin
            r_gnt   <= 2'b00;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_gnt   <= 2'b00;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fasm_dpsram_arb.sv
module tb_fasm_dpsram_arb;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] adat_i = '0;
  logic [AW-1:0] aadr_i = '0;
  logic          awre_i = 1'b0;
  logic          astb_i = 1'b0;
  logic          alck_i = 1'b0;
  logic [DW-1:0] adat_o;
  logic          aack_o;
  logic [DW-1:0] bdat_i = '0;
  logic [AW-1:0] badr_i = '0;
  logic          bwre_i = 1'b0;
  logic          bstb_i = 1'b0;
  logic          blck_i = 1'b0;
  logic [DW-1:0] bdat_o;
  logic          back_o;
  logic [DW-1:0] mdat_o;
  logic [AW-1:0] madr_o;
  logic          mwre_o;
  logic          mstb_o;
  logic [DW-1:0] mdat_i;
  logic [1:0]    gnt_o;

  int n_checks = 0;
  int n_errors = 0;

  fasm_dpsram_arb #(.AW(AW), .DW(DW)) dut (
    .clk_i (clk_i),  .rst_i (rst_i),
    .adat_i(adat_i), .aadr_i(aadr_i), .awre_i(awre_i), .astb_i(astb_i),
    .alck_i(alck_i), .adat_o(adat_o), .aack_o(aack_o),
    .bdat_i(bdat_i), .badr_i(badr_i), .bwre_i(bwre_i), .bstb_i(bstb_i),
    .blck_i(blck_i), .bdat_o(bdat_o), .back_o(back_o),
    .mdat_o(mdat_o), .madr_o(madr_o), .mwre_o(mwre_o), .mstb_o(mstb_o),
    .mdat_i(mdat_i), .gnt_o (gnt_o)
  );

  always #5 clk_i = ~clk_i;

  // SRAM port: registered address, 1-cycle read, write-through.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  logic [DW-1:0] sram_q = '0;
  always @(posedge clk_i) begin
    if (mstb_o) begin
      if (mwre_o) begin
        sram[madr_o] <= mdat_o;
        sram_q       <= mdat_o;
      end else begin
        sram_q <= sram[madr_o];
      end
    end
  end
  assign mdat_i = sram_q;

  // Reference model: expected memory contents and last-served master.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            m_last;  // 0 = A, 1 = B

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected read data for a served access, updating the model on writes.
  function automatic logic [DW-1:0] serve(input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                                          input bit we);
    if (we) ref_mem[adr] = wd;
    return ref_mem[adr];
  endfunction

  // One arbitration round from IDLE: each selected master issues one access.
  // Expected ack cycles come from the rules: first served at +2, second at +4.
  task automatic do_round(input bit ra, input bit rb,
                          input logic [AW-1:0] aa, input logic [DW-1:0] ad, input bit aw,
                          input logic [AW-1:0] ba, input logic [DW-1:0] bd, input bit bw);
    int ack_a, ack_b;
    bit a_first;
    logic [1:0] eg;
    a_first = (ra && rb) ? m_last : ra;
    ack_a = 0;
    ack_b = 0;
    if (ra && rb) begin
      ack_a = a_first ? 2 : 4;
      ack_b = a_first ? 4 : 2;
    end else if (ra) begin
      ack_a = 2;
    end else if (rb) begin
      ack_b = 2;
    end
    aadr_i = aa; adat_i = ad; awre_i = aw; astb_i = ra;
    badr_i = ba; bdat_i = bd; bwre_i = bw; bstb_i = rb;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk_i); #1;
      chk("aack", 32'(aack_o), 32'(c == ack_a));
      chk("back", 32'(back_o), 32'(c == ack_b));
      chk("mstb", 32'(mstb_o), 32'((c == ack_a - 1) || (c == ack_b - 1)));
      eg = {(c == ack_b) || (c == ack_b - 1), (c == ack_a) || (c == ack_a - 1)};
      chk("gnt", 32'(gnt_o), 32'(eg));
      if (c == ack_a - 1) begin
        chk("madr_a", 32'(madr_o), 32'(aa));
        chk("mwre_a", 32'(mwre_o), 32'(aw));
        if (aw) chk("mdat_a", mdat_o, ad);
      end
      if (c == ack_b - 1) begin
        chk("madr_b", 32'(madr_o), 32'(ba));
        chk("mwre_b", 32'(mwre_o), 32'(bw));
        if (bw) chk("mdat_b", mdat_o, bd);
      end
      if (c == ack_a) begin
        chk("adat", adat_o, serve(aa, ad, aw));
        astb_i = 1'b0;
      end
      if (c == ack_b) begin
        chk("bdat", bdat_o, serve(ba, bd, bw));
        bstb_i = 1'b0;
      end
    end
    if (ra && rb) m_last = a_first;
    else if (ra) m_last = 1'b0;
    else if (rb) m_last = 1'b1;
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    m_last = 1'b1;
  endtask

  initial begin
    int na, nb, n_ord;
    logic [4:0] ord, exp_ord;

    for (int i = 0; i < (1 << AW); i++) begin
      sram[i]    = 32'h5A00_0000 ^ (i * 32'h0001_0203);
      ref_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
    end
    sram[5]    = 32'h0000_1234;
    ref_mem[5] = 32'h0000_1234;
    m_last     = 1'b1;

    // Reset state
    @(posedge clk_i); #1;
    chk("rst_aack", 32'(aack_o), 32'd0);
    chk("rst_back", 32'(back_o), 32'd0);
    chk("rst_mstb", 32'(mstb_o), 32'd0);
    chk("rst_gnt",  32'(gnt_o),  32'd0);
    rst_i = 1'b0;

    // A reads 0x05
    do_round(1'b1, 1'b0, 8'h05, 32'h0, 1'b0, 8'h00, 32'h0, 1'b0);
    // A writes 0xCAFE to 0x10, then reads it back
    do_round(1'b1, 1'b0, 8'h10, 32'h0000_CAFE, 1'b1, 8'h00, 32'h0, 1'b0);
    do_round(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 8'h00, 32'h0, 1'b0);
    chk("rd_cafe", ref_mem[8'h10], 32'h0000_CAFE);
    // B alone
    do_round(1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 8'h05, 32'h0, 1'b0);

    // Both request in the same cycle right after reset: A first, then B
    pulse_reset();
    do_round(1'b1, 1'b1, 8'h20, 32'h1111_2222, 1'b1, 8'h20, 32'h0, 1'b0);

    // Both held continuously for 8 accesses: A,B,A,B,... one per 2 cycles
    pulse_reset();
    aadr_i = 8'h03; awre_i = 1'b0; astb_i = 1'b1;
    badr_i = 8'h04; bwre_i = 1'b0; bstb_i = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk_i); #1;
      chk("alt_aack", 32'(aack_o), 32'((c % 4) == 2));
      chk("alt_back", 32'(back_o), 32'((c % 4) == 0));
      chk("alt_gnt",  32'(gnt_o),  (((c % 4) == 1) || ((c % 4) == 2)) ? 32'd1 : 32'd2);
      if ((c % 4) == 2) chk("alt_adat", adat_o, ref_mem[8'h03]);
      if ((c % 4) == 0) chk("alt_bdat", bdat_o, ref_mem[8'h04]);
    end
    astb_i = 1'b0; bstb_i = 1'b0;
    m_last = 1'b1;
    @(posedge clk_i); #1;
    chk("alt_idle_gnt", 32'(gnt_o), 32'd0);

    // Abort: A drops stb during ACCESS; no ack, last pointer unchanged
    aadr_i = 8'h07; awre_i = 1'b1; adat_i = 32'hDEAD_BEEF; astb_i = 1'b1;
    @(posedge clk_i); #1;
    astb_i = 1'b0;
    #1;
    chk("abort_mstb", 32'(mstb_o), 32'd0);
    chk("abort_gnt",  32'(gnt_o),  32'd1);
    @(posedge clk_i); #1;
    chk("abort_aack", 32'(aack_o), 32'd0);
    chk("abort_gnt2", 32'(gnt_o),  32'd0);
    do_round(1'b1, 1'b1, 8'h07, 32'h0, 1'b0, 8'h08, 32'h0, 1'b0);

    // Reset during ACCESS: outputs drop immediately, pending write is lost
    aadr_i = 8'h09; adat_i = 32'h0BAD_F00D; awre_i = 1'b1; astb_i = 1'b1;
    @(posedge clk_i); #1;
    chk("mid_mstb_pre", 32'(mstb_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("mid_aack", 32'(aack_o), 32'd0);
    chk("mid_mstb", 32'(mstb_o), 32'd0);
    chk("mid_gnt",  32'(gnt_o),  32'd0);
    @(posedge clk_i); #1;
    astb_i = 1'b0; awre_i = 1'b0;
    rst_i  = 1'b0;
    m_last = 1'b1;
    do_round(1'b1, 1'b0, 8'h09, 32'h0, 1'b0, 8'h00, 32'h0, 1'b0);

    // Lock: A wants 3 accesses holding lck, B wants 2
    pulse_reset();
    na = 0; nb = 0; n_ord = 0; ord = '0;
    aadr_i = 8'h0A; awre_i = 1'b0; astb_i = 1'b1; alck_i = 1'b1;
    badr_i = 8'h0B; bwre_i = 1'b0; bstb_i = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk_i); #1;
      if (aack_o) begin
        chk("lck_adat", adat_o, ref_mem[8'h0A]);
        if (n_ord < 5) ord[n_ord] = 1'b0;
        n_ord++;
        na++;
        if (na == 3) begin astb_i = 1'b0; alck_i = 1'b0; end
      end
      if (back_o) begin
        chk("lck_bdat", bdat_o, ref_mem[8'h0B]);
        if (n_ord < 5) ord[n_ord] = 1'b1;
        n_ord++;
        nb++;
        if (nb == 2) bstb_i = 1'b0;
      end
    end
    astb_i = 1'b0; bstb_i = 1'b0; alck_i = 1'b0;
`ifdef FASM_ARB_LOCK_EN
    exp_ord = 5'b11000;
`else
    exp_ord = 5'b01010;
`endif
    chk("lck_count", 32'(n_ord), 32'd5);
    for (int i = 0; i < 5; i++) chk("lck_order", 32'(ord[i]), 32'(exp_ord[i]));
    pulse_reset();

    // Randomized rounds against the model
    for (int r = 0; r < 40; r++) begin
      int p;
      p = $urandom_range(1, 3);
      do_round(p[0], p[1],
               AW'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
